nexus_nonce_reporter: RTL and testbench

Result-side consumer of the SK1024 hash pipeline (FirstSkeinRound → SecondSkeinRound → NexusKeccak1024). It takes the in-order 64-bit Keccak output stream and recovers the nonce that produced each hash by counting valid results from a loaded start nonce. It compares each hash against a runtime target and queues winning nonces in a small FIFO. The host drains that FIFO through a valid/ready handshake.

---
 rtl/nexus_pkg.sv | 15 +
 rtl/nexus_nonce_fifo.sv | 55 +++++
 rtl/nexus_nonce_reporter.sv | 64 ++++++
 tb/tb_nexus_nonce_reporter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nexus_pkg.sv
// Shared constants and helpers for the Nexus SK1024 result path.
package nexus_pkg;

  localparam int NONCE_W        = 64;
  localparam int HASH_W         = 64;
  localparam int SK1024_LATENCY = 390;

  function automatic logic isWin(
    input logic [HASH_W-1:0] hash,
    input logic [HASH_W-1:0] target
  );
    return hash <= target;
  endfunction

endpackage

// File: rtl/nexus_nonce_fifo.sv
// First-word-fall-through queue for winning nonces.
module nexus_nonce_fifo
  import nexus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = NONCE_W
) (
  input  logic         clk,
  input  logic         nHashRst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic [W-1:0] lastHead;
  logic         doPush;
  logic         doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  // Keep the last popped word visible while the queue is empty.
  assign head = empty ? lastHead : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!nHashRst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      lastHead <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) begin
        rdPtr    <= rdPtr + 1'b1;
        lastHead <= mem[rdPtr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/nexus_nonce_reporter.sv
// Recovers nonces for in-order SK1024 results and queues the winners.
module nexus_nonce_reporter
  import nexus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 48
) (
  input  logic               clk,
  input  logic               nHashRst,
  input  logic [63:0]        StartNonce,
  input  logic [63:0]        Target,
  input  logic               HashValid,
  input  logic [63:0]        Hash,
  output logic [63:0]        NonceOut,
  output logic               NonceValid,
  input  logic               NonceReady,
  output logic               Overflow,
  output logic [CNT_W-1:0]   HashCount
);

  logic [NONCE_W-1:0] nextNonce;
  logic [NONCE_W-1:0] nonce1;
  logic               win1;
  logic               fifoEmpty;
  logic               fifoFull;
  logic               pop;

  assign NonceValid = ~fifoEmpty;
  assign pop        = NonceValid & NonceReady;

  always_ff @(posedge clk) begin
    if (!nHashRst) begin
      nextNonce <= StartNonce;
      nonce1    <= '0;
      win1      <= 1'b0;
      HashCount <= '0;
      Overflow  <= 1'b0;
    end else begin
      win1 <= HashValid & isWin(Hash, Target);
      if (HashValid) begin
        nonce1    <= nextNonce;
        nextNonce <= nextNonce + 1'b1;
        if (~&HashCount) HashCount <= HashCount + 1'b1;
      end
      // A pop in the same cycle frees the slot, so only a blocked push drops.
      if (win1 && fifoFull && !pop) Overflow <= 1'b1;
    end
  end

  nexus_nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (NONCE_W)
  ) uFifo (
    .clk      (clk),
    .nHashRst (nHashRst),
    .push     (win1),
    .din      (nonce1),
    .pop      (pop),
    .head     (NonceOut),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

endmodule

// File: tb/tb_nexus_nonce_reporter.sv
// Scoreboard bench for nexus_nonce_reporter.
module tb_nexus_nonce_reporter;

  logic        clk = 1'b0;
  logic        nHashRst;
  logic [63:0] StartNonce;
  logic [63:0] Target;
  logic        HashValid;
  logic [63:0] Hash;
  logic [63:0] NonceOut;
  logic        NonceValid;
  logic        NonceReady;
  logic        Overflow;
  logic [47:0] HashCount;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [63:0] expQ [$];

  always #5 clk = ~clk;

  nexus_nonce_reporter #(
    .FIFO_DEPTH (4),
    .CNT_W      (48)
  ) dut (
    .clk        (clk),
    .nHashRst   (nHashRst),
    .StartNonce (StartNonce),
    .Target     (Target),
    .HashValid  (HashValid),
    .Hash       (Hash),
    .NonceOut   (NonceOut),
    .NonceValid (NonceValid),
    .NonceReady (NonceReady),
    .Overflow   (Overflow),
    .HashCount  (HashCount)
  );

  // Monitor: every handshake must match the oldest expected nonce.
  always @(negedge clk) begin
    if (nHashRst && NonceValid && NonceReady) begin
      tests++;
      pops++;
      if (expQ.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected got %h want none", NonceOut);
      end else begin
        if (NonceOut !== expQ[0]) begin
          fails++;
          $display("FAIL pop_order got %h want %h", NonceOut, expQ[0]);
        end
        void'(expQ.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hashIn(input logic v, input logic [63:0] h);
    HashValid = v;
    Hash      = h;
    step();
    HashValid = 1'b0;
    Hash      = '0;
  endtask

  task automatic doReset(input logic [63:0] sn);
    StartNonce = sn;
    nHashRst   = 1'b0;
    step();
    nHashRst   = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (expQ.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s drain_timeout got %0d left want 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    int p0;
    nHashRst   = 1'b0;
    StartNonce = '0;
    Target     = '0;
    HashValid  = 1'b0;
    Hash       = '0;
    NonceReady = 1'b0;
    step();
    step();
    check("rst_nonceout", NonceOut, 64'h0);
    check("rst_valid", {63'b0, NonceValid}, 64'h0);
    check("rst_overflow", {63'b0, Overflow}, 64'h0);
    check("rst_count", {16'b0, HashCount}, 64'h0);

    // Single win on the third result.
    Target     = 64'h0000_0000_FFFF_FFFF;
    NonceReady = 1'b1;
    doReset(64'h0000_0001_FCAF_C044);
    p0 = pops;
    expQ.push_back(64'h0000_0001_FCAF_C046);
    hashIn(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    hashIn(1'b1, 64'h1234_5678_0000_0000);
    hashIn(1'b1, 64'h0000_0000_DEAD_BEEF);
    drain("single");
    repeat (3) step();
    check("single_pops", 64'(pops - p0), 64'd1);
    check("single_count", {16'b0, HashCount}, 64'd3);
    check("single_ovf", {63'b0, Overflow}, 64'h0);

    // Burst of six wins into a four-deep queue.
    Target     = '1;
    NonceReady = 1'b0;
    doReset(64'h10);
    for (int i = 0; i < 6; i++) hashIn(1'b1, 64'(i * 7));
    repeat (2) step();
    check("burst_ovf", {63'b0, Overflow}, 64'h1);
    check("burst_valid", {63'b0, NonceValid}, 64'h1);
    check("burst_head", NonceOut, 64'h10);
    check("burst_count", {16'b0, HashCount}, 64'd6);
    expQ.push_back(64'h10);
    expQ.push_back(64'h11);
    expQ.push_back(64'h12);
    expQ.push_back(64'h13);
    NonceReady = 1'b1;
    drain("burst");
    check("burst_empty", {63'b0, NonceValid}, 64'h0);
    check("burst_hold", NonceOut, 64'h13);

    // Push into a full queue on the same edge as a pop.
    NonceReady = 1'b0;
    doReset(64'h20);
    for (int i = 0; i < 4; i++) hashIn(1'b1, 64'h5);
    repeat (2) step();
    hashIn(1'b1, 64'h5);
    NonceReady = 1'b1;
    for (int i = 0; i < 5; i++) expQ.push_back(64'h20 + 64'(i));
    drain("fullpop");
    check("fullpop_ovf", {63'b0, Overflow}, 64'h0);

    // Gapped valid across the 64-bit wrap.
    doReset(64'hFFFF_FFFF_FFFF_FFFE);
    expQ.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    expQ.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    expQ.push_back(64'h0);
    hashIn(1'b1, 64'hA);
    hashIn(1'b0, 64'h0);
    hashIn(1'b0, 64'h0);
    hashIn(1'b1, 64'hB);
    hashIn(1'b1, 64'hC);
    drain("wrap");
    check("wrap_count", {16'b0, HashCount}, 64'd3);

    // Compare boundaries.
    Target = 64'h100;
    doReset(64'h40);
    expQ.push_back(64'h40);
    expQ.push_back(64'h42);
    hashIn(1'b1, 64'h100);
    hashIn(1'b1, 64'h101);
    Target = 64'h0;
    hashIn(1'b1, 64'h0);
    hashIn(1'b1, 64'h1);
    drain("bound");
    repeat (3) step();
    check("bound_count", {16'b0, HashCount}, 64'd4);
    check("bound_valid", {63'b0, NonceValid}, 64'h0);

    // Reset while the queue is full and Overflow is set.
    Target     = '1;
    NonceReady = 1'b0;
    doReset(64'h60);
    for (int i = 0; i < 6; i++) hashIn(1'b1, 64'h9);
    repeat (2) step();
    check("mid_ovf_set", {63'b0, Overflow}, 64'h1);
    doReset(64'h500);
    check("mid_valid", {63'b0, NonceValid}, 64'h0);
    check("mid_ovf", {63'b0, Overflow}, 64'h0);
    check("mid_count", {16'b0, HashCount}, 64'h0);
    NonceReady = 1'b1;
    expQ.push_back(64'h500);
    hashIn(1'b1, 64'h1);
    drain("mid");
    check("mid_count1", {16'b0, HashCount}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
